// File: rtl/zeroriscy_dmem_pkg.sv
// Shared types and widths for the data-memory arbiter slice.
package zeroriscy_dmem_pkg;

  // Identifies which master issued a transaction.
  typedef enum logic {
    MST_CORE = 1'b0,
    MST_AUX  = 1'b1
  } mst_id_e;

  localparam int DMEM_BE_W = 4;
  localparam int DMEM_DW   = 32;

endpackage

// File: rtl/zeroriscy_id_fifo.sv
// Small in-order FIFO holding the issuing-master ID of each outstanding access.
// A push and a pop in the same cycle are accepted even when the FIFO is full.
module zeroriscy_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointers wrap modulo DEPTH, which also covers a depth of one.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == PW'(DEPTH - 1)) begin
      r = {PW{1'b0}};
    end else begin
      r = p + PW'(1);
    end
    return r;
  endfunction

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_push_s = push & (~full | pop);
  assign do_pop_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage and write pointer advance on every accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
      wr_ptr_r        <= ptr_inc(wr_ptr_r);
    end
  end

  // Read pointer advances on every pop of a non-empty FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {PW{1'b0}};
    end else if (do_pop_s) begin
      rd_ptr_r <= ptr_inc(rd_ptr_r);
    end
  end

  // Occupancy is unchanged when push and pop coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/zeroriscy_dmem_arb.sv
// Round-robin arbiter sharing one data-SRAM port between the core LSU (m0)
// and an auxiliary master (m1). Responses are steered back by an ID FIFO.
module zeroriscy_dmem_arb
  import zeroriscy_dmem_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int AW          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [DMEM_BE_W-1:0] m0_be,
  input  logic [AW-1:0]        m0_addr,
  input  logic [DMEM_DW-1:0]   m0_wdata,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [DMEM_DW-1:0]   m0_rdata,
  output logic                 m0_err,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [DMEM_BE_W-1:0] m1_be,
  input  logic [AW-1:0]        m1_addr,
  input  logic [DMEM_DW-1:0]   m1_wdata,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [DMEM_DW-1:0]   m1_rdata,
  output logic                 m1_err,
  output logic                 s_req,
  output logic                 s_we,
  output logic [DMEM_BE_W-1:0] s_be,
  output logic [AW-1:0]        s_addr,
  output logic [DMEM_DW-1:0]   s_wdata,
  input  logic                 s_gnt,
  input  logic                 s_rvalid,
  input  logic [DMEM_DW-1:0]   s_rdata,
  input  logic                 s_err,
  output logic                 proto_err
);

  localparam int CW = $clog2(OUTSTANDING + 1);

  mst_id_e       last_r;
  mst_id_e       winner_s;
  mst_id_e       head_id_s;
  logic [0:0]    push_id_s;
  logic [0:0]    head_s;
  logic [CW-1:0] count_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          full_eff_s;
  logic          push_s;
  logic          pop_s;
  logic          proto_err_r;

  // Single requester wins outright; on contention the master not served last wins.
  always_comb begin
    winner_s = MST_CORE;
    if (m0_req && m1_req) begin
      if (last_r == MST_CORE) begin
        winner_s = MST_AUX;
      end else begin
        winner_s = MST_CORE;
      end
    end else if (m1_req) begin
      winner_s = MST_AUX;
    end else begin
      winner_s = MST_CORE;
    end
  end

  // A response in the same cycle frees a slot, so a full FIFO can still accept.
  assign full_eff_s = fifo_full_s & ~s_rvalid;
  assign s_req      = (m0_req | m1_req) & ~full_eff_s & ~rst;
  assign push_s     = s_req & s_gnt;
  assign pop_s      = s_rvalid & (count_s != {CW{1'b0}}) & ~rst;
  assign push_id_s  = winner_s;
  assign head_id_s  = mst_id_e'(head_s);
  assign m0_gnt     = push_s & (winner_s == MST_CORE);
  assign m1_gnt     = push_s & (winner_s == MST_AUX);
  assign proto_err  = proto_err_r;

  // Forward the winner's payload; the slave bus is quiet when nothing is requested.
  always_comb begin
    s_we    = 1'b0;
    s_be    = {DMEM_BE_W{1'b0}};
    s_addr  = {AW{1'b0}};
    s_wdata = {DMEM_DW{1'b0}};
    if (s_req) begin
      case (winner_s)
        MST_CORE: begin
          s_we    = m0_we;
          s_be    = m0_be;
          s_addr  = m0_addr;
          s_wdata = m0_wdata;
        end
        MST_AUX: begin
          s_we    = m1_we;
          s_be    = m1_be;
          s_addr  = m1_addr;
          s_wdata = m1_wdata;
        end
        default: begin
          s_we    = 1'b0;
          s_be    = {DMEM_BE_W{1'b0}};
          s_addr  = {AW{1'b0}};
          s_wdata = {DMEM_DW{1'b0}};
        end
      endcase
    end else begin
      s_we    = 1'b0;
      s_be    = {DMEM_BE_W{1'b0}};
      s_addr  = {AW{1'b0}};
      s_wdata = {DMEM_DW{1'b0}};
    end
  end

  // Steer each slave response to the master at the head of the ID FIFO only.
  always_comb begin
    m0_rvalid = 1'b0;
    m0_rdata  = {DMEM_DW{1'b0}};
    m0_err    = 1'b0;
    m1_rvalid = 1'b0;
    m1_rdata  = {DMEM_DW{1'b0}};
    m1_err    = 1'b0;
    if (pop_s) begin
      case (head_id_s)
        MST_CORE: begin
          m0_rvalid = 1'b1;
          m0_rdata  = s_rdata;
          m0_err    = s_err;
        end
        MST_AUX: begin
          m1_rvalid = 1'b1;
          m1_rdata  = s_rdata;
          m1_err    = s_err;
        end
        default: begin
          m0_rvalid = 1'b0;
          m1_rvalid = 1'b0;
        end
      endcase
    end else begin
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
    end
  end

  // Remember the last granted master; reset favours m0 on first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= MST_AUX;
    end else if (push_s) begin
      last_r <= winner_s;
    end
  end

  // Sticky flag for a slave response with nothing outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err_r <= 1'b0;
    end else if (s_rvalid && fifo_empty_s) begin
      proto_err_r <= 1'b1;
    end
  end

  zeroriscy_id_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (1)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_id_s),
    .dout  (head_s),
    .count (count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

endmodule

// File: tb/tb_zeroriscy_dmem_arb.sv
// Self-checking bench for zeroriscy_dmem_arb: directed vector table,
// hand-written corner sequences and a randomized run against a queue model.
module tb_zeroriscy_dmem_arb;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we, s_gnt, s_rvalid, s_err, proto_err;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wdata, s_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        m0_req, m1_req, s_gnt, s_rvalid;
    logic        e_g0, e_g1, e_rv0, e_rv1, e_sreq;
    logic [31:0] e_addr;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  vec_t        vt [10];
  rsp_t        slq [$];
  logic [31:0] mem [16];

  zeroriscy_dmem_arb #(.OUTSTANDING(2), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_be = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_be = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
    s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h0; s_err = 1'b0;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_sreq"}, {31'd0, s_req}, 32'd0);
    chk({nm, "_gnt"}, {30'd0, m0_gnt, m1_gnt}, 32'd0);
    chk({nm, "_rvalid"}, {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    chk({nm, "_rdata"}, m0_rdata | m1_rdata, 32'd0);
    chk({nm, "_err"}, {30'd0, m0_err, m1_err}, 32'd0);
    chk({nm, "_payload"}, s_addr | s_wdata | {27'd0, s_we, s_be}, 32'd0);
  endtask

  initial begin
    logic        rv, full, esreq, win, eg, we;
    logic [31:0] addr;
    rsp_t        r;

    // m0_req m1_req s_gnt s_rvalid | g0 g1 rv0 rv1 sreq addr
    vt[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10};
    vt[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20};
    vt[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10};
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20};
    vt[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10};
    vt[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00};
    vt[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20};
    vt[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10};
    vt[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00};

    // Reset: outputs must be quiet even with requests and responses present.
    idle_inputs();
    rst = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h44; m0_wdata = 32'h55;
    s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h1234_5678; s_err = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_proto_err", {31'd0, proto_err}, 32'd0);
    idle_inputs();
    rst = 1'b0;

    // Directed vector table, applied cycle by cycle from reset.
    m0_addr = 32'h10; m1_addr = 32'h20; m0_wdata = 32'h0A0A_0A0A; m1_wdata = 32'h0B0B_0B0B;
    m0_be = 4'h3; m1_be = 4'hC;
    for (int i = 0; i < 10; i++) begin
      m0_req = vt[i].m0_req; m1_req = vt[i].m1_req;
      s_gnt = vt[i].s_gnt; s_rvalid = vt[i].s_rvalid;
      s_rdata = 32'hA000_0000 + 32'(i);
      s_err = (i % 2 == 1) ? 1'b1 : 1'b0;
      #4;
      chk($sformatf("vec%0d_m0_gnt", i), {31'd0, m0_gnt}, {31'd0, vt[i].e_g0});
      chk($sformatf("vec%0d_m1_gnt", i), {31'd0, m1_gnt}, {31'd0, vt[i].e_g1});
      chk($sformatf("vec%0d_s_req", i), {31'd0, s_req}, {31'd0, vt[i].e_sreq});
      chk($sformatf("vec%0d_s_addr", i), s_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_m0_rvalid", i), {31'd0, m0_rvalid}, {31'd0, vt[i].e_rv0});
      chk($sformatf("vec%0d_m1_rvalid", i), {31'd0, m1_rvalid}, {31'd0, vt[i].e_rv1});
      chk($sformatf("vec%0d_m0_rdata", i), m0_rdata, vt[i].e_rv0 ? s_rdata : 32'h0);
      chk($sformatf("vec%0d_m1_rdata", i), m1_rdata, vt[i].e_rv1 ? s_rdata : 32'h0);
      chk($sformatf("vec%0d_m0_err", i), {31'd0, m0_err}, {31'd0, vt[i].e_rv0 & s_err});
      chk($sformatf("vec%0d_m1_err", i), {31'd0, m1_err}, {31'd0, vt[i].e_rv1 & s_err});
      tick();
    end
    chk("table_proto_err", {31'd0, proto_err}, 32'd0);

    // m0 alone: write then read back through a one-cycle slave.
    idle_inputs();
    m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'hF; m0_addr = 32'h100; m0_wdata = 32'hDEAD_BEEF;
    s_gnt = 1'b1;
    #4;
    chk("wr_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("wr_s_addr", s_addr, 32'h100);
    chk("wr_s_wdata", s_wdata, 32'hDEAD_BEEF);
    chk("wr_s_we_be", {27'd0, s_we, s_be}, 32'h1F);
    tick();
    m0_we = 1'b0; m0_wdata = 32'h0; s_rvalid = 1'b1; s_rdata = 32'h0;
    #4;
    chk("rd_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("wr_rsp_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'h2);
    tick();
    m0_req = 1'b0; s_rdata = 32'hDEAD_BEEF;
    #4;
    chk("rd_rsp_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'h2);
    chk("rd_rsp_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("rd_rsp_m1_rdata", m1_rdata, 32'h0);
    tick();

    // Slave stalls for four cycles while m1 holds its request.
    idle_inputs();
    m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'h6; m1_addr = 32'h200; m1_wdata = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      #4;
      chk($sformatf("stall%0d_m1_gnt", k), {31'd0, m1_gnt}, 32'd0);
      chk($sformatf("stall%0d_s_req", k), {31'd0, s_req}, 32'd1);
      chk($sformatf("stall%0d_s_addr", k), s_addr, 32'h200);
      chk($sformatf("stall%0d_s_wdata", k), s_wdata, 32'h1234_5678);
      tick();
    end
    s_gnt = 1'b1;
    #4;
    chk("stall_release_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    tick();
    m1_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1;
    #4;
    chk("stall_rsp_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'h1);
    tick();

    // Response with nothing outstanding raises a sticky protocol error.
    idle_inputs();
    s_rvalid = 1'b1; s_rdata = 32'h7777_7777;
    #4;
    chk("proto_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    chk("proto_before_edge", {31'd0, proto_err}, 32'd0);
    tick();
    s_rvalid = 1'b0;
    #4;
    chk("proto_set", {31'd0, proto_err}, 32'd1);
    tick();
    chk("proto_sticky", {31'd0, proto_err}, 32'd1);

    // Two outstanding, then reset mid-flight; afterwards contention alternates from m0.
    m0_req = 1'b1; m1_req = 1'b1; s_gnt = 1'b1;
    m0_addr = 32'h10; m1_addr = 32'h20;
    tick();
    tick();
    rst = 1'b1; s_rvalid = 1'b1;
    #2;
    chk_quiet("midrst");
    chk("midrst_proto_err", {31'd0, proto_err}, 32'd0);
    tick();
    rst = 1'b0; s_rvalid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      s_rvalid = (k > 0);
      s_rdata = 32'h5000 + 32'(k);
      #4;
      chk($sformatf("alt%0d_m0_gnt", k), {31'd0, m0_gnt}, {31'd0, k % 2 == 0});
      chk($sformatf("alt%0d_m1_gnt", k), {31'd0, m1_gnt}, {31'd0, k % 2 == 1});
      chk($sformatf("alt%0d_m0_rvalid", k), {31'd0, m0_rvalid}, {31'd0, (k > 0) && ((k - 1) % 2 == 0)});
      chk($sformatf("alt%0d_m1_rvalid", k), {31'd0, m1_rvalid}, {31'd0, (k > 0) && ((k - 1) % 2 == 1)});
      tick();
    end
    chk("alt_proto_err", {31'd0, proto_err}, 32'd0);

    // Randomized run against a queue-based model of the arbiter and an in-order slave.
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    slq.delete();
    win = 1'b0;
    begin
      logic last;
      last = 1'b1;
      for (int c = 0; c < 400; c++) begin
        m0_req = 1'($urandom_range(0, 1)); m1_req = 1'($urandom_range(0, 1));
        m0_we = 1'($urandom_range(0, 1));  m1_we = 1'($urandom_range(0, 1));
        m0_be = 4'($urandom);              m1_be = 4'($urandom);
        m0_addr = {26'd0, 4'($urandom), 2'b00};
        m1_addr = {26'd0, 4'($urandom), 2'b00};
        m0_wdata = $urandom; m1_wdata = $urandom;
        s_gnt = ($urandom_range(0, 3) != 0);
        rv = (slq.size() > 0) && ($urandom_range(0, 2) != 0);
        s_rvalid = rv;
        s_rdata = rv ? slq[0].rdata : 32'h0;
        s_err = rv ? slq[0].err : 1'b0;
        full = (slq.size() == 2) && !rv;
        esreq = (m0_req || m1_req) && !full;
        win = (m0_req && m1_req) ? !last : m1_req;
        eg = esreq && s_gnt;
        addr = win ? m1_addr : m0_addr;
        we = win ? m1_we : m0_we;
        #4;
        chk("rnd_s_req", {31'd0, s_req}, {31'd0, esreq});
        chk("rnd_m0_gnt", {31'd0, m0_gnt}, {31'd0, eg && !win});
        chk("rnd_m1_gnt", {31'd0, m1_gnt}, {31'd0, eg && win});
        chk("rnd_s_addr", s_addr, esreq ? addr : 32'h0);
        chk("rnd_s_wdata", s_wdata, esreq ? (win ? m1_wdata : m0_wdata) : 32'h0);
        chk("rnd_s_we_be", {27'd0, s_we, s_be}, esreq ? {27'd0, we, (win ? m1_be : m0_be)} : 32'h0);
        chk("rnd_m0_rvalid", {31'd0, m0_rvalid}, {31'd0, rv && !slq[0].id});
        chk("rnd_m1_rvalid", {31'd0, m1_rvalid}, {31'd0, rv && slq[0].id});
        chk("rnd_m0_rdata", m0_rdata, (rv && !slq[0].id) ? slq[0].rdata : 32'h0);
        chk("rnd_m1_rdata", m1_rdata, (rv && slq[0].id) ? slq[0].rdata : 32'h0);
        chk("rnd_err", {30'd0, m0_err, m1_err},
            {30'd0, rv && !slq[0].id && slq[0].err, rv && slq[0].id && slq[0].err});
        if (rv) void'(slq.pop_front());
        if (eg) begin
          r.id = win;
          r.err = 1'($urandom_range(0, 1));
          if (we) begin
            r.rdata = 32'h0;
            mem[addr[5:2]] = win ? m1_wdata : m0_wdata;
          end else begin
            r.rdata = mem[addr[5:2]];
          end
          slq.push_back(r);
          last = win;
        end
        tick();
      end
    end
    chk("rnd_proto_err", {31'd0, proto_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
